// File: rtl/fake_sink.sv
// Test sink that accepts valid/ready beats, records the last payload and counts transfers.
// The stall input forces backpressure so sources can be exercised against a stalled consumer.
module fake_sink #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned COUNTER_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_WIDTH-1:0]    data,
  input  logic                     valid,
  output logic                     ready,
  input  logic                     stall,
  output logic [DATA_WIDTH-1:0]    last_value,
  output logic [COUNTER_WIDTH-1:0] num_values
);

  logic transfer;

  // ready is purely combinational so that reset and stall gate acceptance in the same cycle.
  always_comb begin
    ready    = reset_n & ~stall;
    transfer = valid & ready;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      last_value <= '0;
      num_values <= '0;
    end else if (transfer) begin
      last_value <= data;
      num_values <= num_values + 1'b1;
    end
  end

endmodule

// File: tb/tb_fake_sink.sv
// Directed, table-driven bench for fake_sink with hand-computed expectations.
module tb_fake_sink;

  logic       clk;
  logic       reset_n;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       stall;
  logic [7:0] last_value;
  logic [3:0] num_values;

  int unsigned n_checks;
  int unsigned n_fail;

  fake_sink #(.DATA_WIDTH(8), .COUNTER_WIDTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .stall      (stall),
    .last_value (last_value),
    .num_values (num_values)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       valid;
    logic       stall;
    logic [7:0] data;
    logic       exp_ready;
    logic [7:0] exp_last;
    logic [3:0] exp_num;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_known(input string name);
    n_checks++;
    if ($isunknown({last_value, num_values, ready})) begin
      n_fail++;
      $display("FAIL %s: unknown output last=%h num=%h ready=%b", name, last_value, num_values, ready);
    end
  endtask

  // Drive inputs just after a rising edge, check ready before the next edge, outputs after it.
  task automatic apply(input logic r, input logic v, input logic s, input logic [7:0] d);
    reset_n = r;
    valid   = v;
    stall   = s;
    data    = d;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    valid    = 1'b0;
    stall    = 1'b0;
    data     = 8'h00;

    //          rst   v     s     data   rdy   last   num
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 4'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h12, 1'b1, 8'h12, 4'd1};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 8'h34, 1'b1, 8'h34, 4'd2};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 8'h56, 1'b1, 8'h56, 4'd3};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h78, 1'b0, 8'h56, 4'd3};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'h78, 1'b0, 8'h56, 4'd3};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 8'h78, 1'b1, 8'h78, 4'd4};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'hxx, 1'b1, 8'h78, 4'd4};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'hxx, 1'b1, 8'h78, 4'd4};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 8'h99, 1'b0, 8'h78, 4'd4};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 8'h9a, 1'b0, 8'h00, 4'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 8'hab, 1'b1, 8'hab, 4'd1};

    step();
    for (int i = 0; i < 12; i++) begin
      apply(vecs[i].rst_n, vecs[i].valid, vecs[i].stall, vecs[i].data);
      chk($sformatf("v%0d.ready", i), 32'(ready), 32'(vecs[i].exp_ready));
      step();
      chk($sformatf("v%0d.last_value", i), 32'(last_value), 32'(vecs[i].exp_last));
      chk($sformatf("v%0d.num_values", i), 32'(num_values), 32'(vecs[i].exp_num));
      chk_known($sformatf("v%0d.known", i));
    end

    // Wrap: 16 back-to-back transfers from reset return the counter to 0.
    apply(1'b0, 1'b0, 1'b0, 8'h00);
    step();
    chk("wrap.reset_num", 32'(num_values), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      apply(1'b1, 1'b1, 1'b0, 8'(8'hc0 + i));
      step();
      chk($sformatf("wrap.num%0d", i), 32'(num_values), 32'(i % 16));
      chk($sformatf("wrap.last%0d", i), 32'(last_value), 32'(8'hc0 + i));
    end
    chk("wrap.final_last", 32'(last_value), 32'h00d0);
    apply(1'b1, 1'b1, 1'b0, 8'h5a);
    step();
    chk("wrap.post_num", 32'(num_values), 32'd1);
    chk("wrap.post_last", 32'(last_value), 32'h5a);

    // Reset in the middle of a burst discards the beat and restarts the count.
    apply(1'b1, 1'b1, 1'b0, 8'h11);
    step();
    chk("mid.num_before", 32'(num_values), 32'd2);
    apply(1'b0, 1'b1, 1'b0, 8'h22);
    chk("mid.ready_in_reset", 32'(ready), 32'd0);
    step();
    chk("mid.num_after", 32'(num_values), 32'd0);
    chk("mid.last_after", 32'(last_value), 32'd0);
    apply(1'b1, 1'b1, 1'b0, 8'h33);
    step();
    chk("mid.restart_num", 32'(num_values), 32'd1);
    chk("mid.restart_last", 32'(last_value), 32'h33);
    apply(1'b1, 1'b0, 1'b0, 8'h00);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fake_sink.md
FAKE_SINK -- requirements
Module: fake_sink

Interface
REQ-001 The module SHALL use one clock; reset is synchronous and active-low.
REQ-002 Parameter DATA_WIDTH, default 8: width of the data payload, last_value and the data bus.
REQ-003 Parameter COUNTER_WIDTH, default 4: width of the num_values transfer counter.
REQ-004 The module SHALL have these ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- data  input  DATA_WIDTH  payload from upstream source.
- valid  input  1  upstream asserts when data is meaningful.
- ready  output  1  sink can accept a beat this cycle.
- stall  input  1  test control; forces backpressure while high.
- last_value  output  DATA_WIDTH  payload of most recent accepted beat.
- num_values  output  COUNTER_WIDTH  count of accepted beats, modulo 2^COUNTER_WIDTH.

Function
REQ-005 ready SHALL be combinational: ready = reset_n AND NOT stall; no register stage.
REQ-006 A transfer SHALL occur at a rising clk edge iff reset_n=1, valid=1 and ready=1 in the preceding cycle.
REQ-007 On a transfer, last_value SHALL load data, visible the cycle after the edge (1-cycle latency).
REQ-008 On a transfer, num_values SHALL increment by 1, wrapping from 2^COUNTER_WIDTH-1 to 0 with no flag or saturation.
REQ-009 Without a transfer, last_value and num_values SHALL hold their values.
REQ-010 While valid=0, data SHALL be ignored, including X/unknown values; no output may become X.
REQ-011 While stall=1, no transfer SHALL occur regardless of valid; data held by the source across stall cycles SHALL be accepted exactly once, on the first edge with stall=0.
REQ-012 valid=1 with ready=1 on consecutive cycles SHALL accept one beat per cycle (full throughput, no bubbles).
REQ-013 The module SHALL keep no other state; no buffering or FIFO is required.

Reset
REQ-014 While reset_n=0 at a rising edge, last_value SHALL become 0 and num_values SHALL become 0.
REQ-015 While reset_n=0, ready SHALL be 0 and no transfer SHALL occur, even if valid=1 and stall=0.
REQ-016 Reset asserted mid-stream SHALL take priority over a simultaneous transfer; the beat is discarded and the counter restarts from 0.

Verification
REQ-017 Reset for one cycle with valid=0 -> last_value=0x00, num_values=0, ready=0 during reset and 1 after (stall=0).
REQ-018 After reset, present 0x12, 0x34, 0x56 with valid=1 and stall=0 on three consecutive cycles -> num_values steps 1, 2, 3; last_value steps 0x12, 0x34, 0x56.
REQ-019 Continuing, hold data=0x78 and valid=1 with stall=1 for two cycles, then stall=0 for one cycle -> ready=0 while stalled, with num_values=3 and last_value=0x56 unchanged; after the unstall edge, num_values=4 and last_value=0x78.
REQ-020 Continuing, set valid=0 and data=X for two cycles -> outputs hold at 4 and 0x78 with no X.
REQ-021 With COUNTER_WIDTH=4, perform 16 back-to-back transfers from reset -> num_values wraps to 0 and last_value equals the 16th data value.
REQ-022 Assert reset_n=0 in the same cycle as valid=1 and stall=0 -> no transfer occurs, and num_values=0 and last_value=0 after the edge.
